// File: rtl/interrupt_ctrl_if.sv
// rtl/interrupt_ctrl_if.sv - vector request/acknowledge handshake between interrupt controller and CPU
interface interrupt_ctrl_if;
    logic       int_req;
    logic [7:0] int_vect;
    logic       int_ack;

    modport master (output int_req, output int_vect, input int_ack);
    modport slave  (input int_req, input int_vect, output int_ack);
endinterface

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - 8051 interrupt arbiter with two-level in-service tracking
// Define T2_INT_EN to let timer 2 (source 5, vector 0x2B) take part in arbitration.
module interrupt_ctrl (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              IE_data,
    input  logic [7:0]              IP_data,
    input  logic [5:0]              src_flags,
    input  logic                    inst_boundary,
    input  logic                    reti,
    interrupt_ctrl_if.master        irq,
    output logic [5:0]              int_clr,
    output logic [1:0]              in_svc
);

`ifdef T2_INT_EN
    localparam logic [5:0] SRC_MASK = 6'h3F;
`else
    localparam logic [5:0] SRC_MASK = 6'h1F;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK} state_t;

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [7:0] vect_q, vect_d;
    logic [2:0] idx_q, idx_d;
    logic       lvl_q, lvl_d;
    logic [5:0] clr_q, clr_d;
    logic [1:0] svc_q, svc_d;

    logic [5:0] eligible, hi_acc, lo_acc, pick;
    logic [2:0] win_idx;
    logic       win_lvl, has_win;
    logic [1:0] svc_after_reti;
    logic       unused_sfr_bits;

    assign unused_sfr_bits = ^{IE_data[6], IP_data[7:6]};

    always_comb begin
        eligible = src_flags & IE_data[5:0] & {6{IE_data[7]}} & SRC_MASK;
        hi_acc   = eligible & IP_data[5:0] & {6{~svc_q[1]}};
        lo_acc   = eligible & ~IP_data[5:0] & {6{svc_q == 2'b00}};
        win_lvl  = |hi_acc;
        pick     = win_lvl ? hi_acc : lo_acc;
        has_win  = |pick;
        win_idx  = 3'd0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = 5; i >= 0; i--) begin
            if (pick[i]) win_idx = 3'(i);
        end
    end

    // RETI retires the most recently entered level: high if active, else low.
    always_comb begin
        svc_after_reti = svc_q;
        if (reti) begin
            if (svc_q[1]) svc_after_reti = {1'b0, svc_q[0]};
            else          svc_after_reti = 2'b00;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vect_d  = vect_q;
        idx_d   = idx_q;
        lvl_d   = lvl_q;
        clr_d   = 6'b0;
        svc_d   = svc_after_reti;
        case (state_q)
            ST_IDLE: begin
                if (inst_boundary && !reti && has_win) begin
                    idx_d   = win_idx;
                    lvl_d   = win_lvl;
                    vect_d  = {2'b00, win_idx, 3'b011};
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq.int_ack) begin
                    req_d        = 1'b0;
                    state_d      = ST_ACK;
                    // Only the external-edge and timer 0/1 flags are hardware-cleared.
                    clr_d        = (idx_q < 3'd4) ? (6'b000001 << idx_q) : 6'b0;
                    svc_d[lvl_q] = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            vect_q  <= 8'h00;
            idx_q   <= 3'd0;
            lvl_q   <= 1'b0;
            clr_q   <= 6'b0;
            svc_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            vect_q  <= vect_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            clr_q   <= clr_d;
            svc_q   <= svc_d;
        end
    end

    assign irq.int_req  = req_q;
    assign irq.int_vect = vect_q;
    assign int_clr      = clr_q;
    assign in_svc       = svc_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - directed and randomized checks of interrupt_ctrl against a transaction model
module tb_interrupt_ctrl;

`ifdef T2_INT_EN
    localparam bit T2 = 1'b1;
`else
    localparam bit T2 = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] IE_data, IP_data;
    logic [5:0] src_flags;
    logic       inst_boundary, reti;
    logic [5:0] int_clr;
    logic [1:0] in_svc;

    interrupt_ctrl_if irq ();

    interrupt_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .IE_data       (IE_data),
        .IP_data       (IP_data),
        .src_flags     (src_flags),
        .inst_boundary (inst_boundary),
        .reti          (reti),
        .irq           (irq),
        .int_clr       (int_clr),
        .in_svc        (in_svc)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [16:0] obs;
    assign obs = {irq.int_req, irq.int_vect, int_clr, in_svc};

    // Transaction-level model: phase 0 waiting, 1 request outstanding, 2 acknowledged.
    int         m_phase;
    int         m_idx, m_lvl;
    logic       m_req;
    logic [7:0] m_vect;
    logic [5:0] m_clr;
    logic [1:0] m_svc;

    function automatic int arbitrate(input logic [1:0] svc, output int lvl);
        for (int l = 1; l >= 0; l--) begin
            if (l == 1 && svc[1]) continue;
            if (l == 0 && svc != 2'b00) continue;
            for (int i = 0; i < 6; i++) begin
                if (i == 5 && !T2) continue;
                if (src_flags[i] && IE_data[i] && IE_data[7] && (int'(IP_data[i]) == l)) begin
                    lvl = l;
                    return i;
                end
            end
        end
        lvl = 0;
        return -1;
    endfunction

    task automatic model_update();
        logic [1:0] nsvc;
        int w, l;
        if (reset) begin
            m_phase = 0; m_req = 0; m_vect = 8'h00; m_clr = 6'h00; m_svc = 2'b00;
            m_idx = 0; m_lvl = 0;
        end else begin
            nsvc = m_svc;
            if (reti) begin
                if (nsvc[1]) nsvc[1] = 1'b0;
                else         nsvc[0] = 1'b0;
            end
            m_clr = 6'h00;
            if (m_phase == 0) begin
                if (inst_boundary && !reti) begin
                    w = arbitrate(m_svc, l);
                    if (w >= 0) begin
                        m_idx = w; m_lvl = l; m_req = 1'b1;
                        m_vect = 8'(8 * w + 3);
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (irq.int_ack) begin
                    m_req = 1'b0;
                    m_phase = 2;
                    if (m_idx < 4) m_clr = 6'(1 << m_idx);
                    nsvc[m_lvl] = 1'b1;
                end
            end else begin
                m_phase = 0;
            end
            m_svc = nsvc;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [7:0] ie, input logic [7:0] ip, input logic [5:0] fl,
                         input logic bnd, input logic rt, input logic ak);
        IE_data = ie; IP_data = ip; src_flags = fl;
        inst_boundary = bnd; reti = rt; irq.int_ack = ak;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b0;
        checks++; if (obs !== 17'h0) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, 17'h0); end
    endtask

    task automatic test_basic();
        drive(8'h81, 8'h00, 6'h01, 1'b1, 1'b0, 1'b0); step();
        checks++; if (obs !== {1'b1, 8'h03, 6'h00, 2'b00}) begin errors++; $display("FAIL basic_req: got %h expected %h", obs, {1'b1, 8'h03, 6'h00, 2'b00}); end
        drive(8'h81, 8'h00, 6'h00, 1'b0, 1'b0, 1'b1); step();
        checks++; if (obs !== {1'b0, 8'h03, 6'h01, 2'b01}) begin errors++; $display("FAIL basic_ack: got %h expected %h", obs, {1'b0, 8'h03, 6'h01, 2'b01}); end
        irq.int_ack = 1'b0; step();
        checks++; if (obs !== {1'b0, 8'h03, 6'h00, 2'b01}) begin errors++; $display("FAIL basic_clr_one_cycle: got %h expected %h", obs, {1'b0, 8'h03, 6'h00, 2'b01}); end
        reti = 1'b1; step(); reti = 1'b0;
        checks++; if (obs !== {1'b0, 8'h03, 6'h00, 2'b00}) begin errors++; $display("FAIL basic_reti: got %h expected %h", obs, {1'b0, 8'h03, 6'h00, 2'b00}); end
    endtask

    task automatic test_priority();
        drive(8'h9F, 8'h08, 6'h09, 1'b1, 1'b0, 1'b0); step();
        checks++; if (obs !== {1'b1, 8'h1B, 6'h00, 2'b00}) begin errors++; $display("FAIL prio_req: got %h expected %h", obs, {1'b1, 8'h1B, 6'h00, 2'b00}); end
        drive(8'h9F, 8'h08, 6'h09, 1'b0, 1'b0, 1'b1); step();
        checks++; if (obs !== {1'b0, 8'h1B, 6'h08, 2'b10}) begin errors++; $display("FAIL prio_ack: got %h expected %h", obs, {1'b0, 8'h1B, 6'h08, 2'b10}); end
        drive(8'h9F, 8'h08, 6'h00, 1'b0, 1'b0, 1'b0); step();
        reti = 1'b1; step(); reti = 1'b0;
        checks++; if (obs !== {1'b0, 8'h1B, 6'h00, 2'b00}) begin errors++; $display("FAIL prio_reti: got %h expected %h", obs, {1'b0, 8'h1B, 6'h00, 2'b00}); end
    endtask

    task automatic test_nesting();
        drive(8'h87, 8'h02, 6'h01, 1'b1, 1'b0, 1'b0); step();
        drive(8'h87, 8'h02, 6'h01, 1'b0, 1'b0, 1'b1); step();
        checks++; if (obs !== {1'b0, 8'h03, 6'h01, 2'b01}) begin errors++; $display("FAIL nest_low_ack: got %h expected %h", obs, {1'b0, 8'h03, 6'h01, 2'b01}); end
        drive(8'h87, 8'h02, 6'h06, 1'b1, 1'b0, 1'b0); step(); step();
        checks++; if (obs !== {1'b1, 8'h0B, 6'h00, 2'b01}) begin errors++; $display("FAIL nest_high_req: got %h expected %h", obs, {1'b1, 8'h0B, 6'h00, 2'b01}); end
        drive(8'h87, 8'h02, 6'h06, 1'b0, 1'b0, 1'b1); step();
        checks++; if (obs !== {1'b0, 8'h0B, 6'h02, 2'b11}) begin errors++; $display("FAIL nest_high_ack: got %h expected %h", obs, {1'b0, 8'h0B, 6'h02, 2'b11}); end
        drive(8'h87, 8'h02, 6'h04, 1'b1, 1'b0, 1'b0); step(); step();
        checks++; if (obs !== {1'b0, 8'h0B, 6'h00, 2'b11}) begin errors++; $display("FAIL nest_blocked_both: got %h expected %h", obs, {1'b0, 8'h0B, 6'h00, 2'b11}); end
        reti = 1'b1; step(); reti = 1'b0; step();
        checks++; if (obs !== {1'b0, 8'h0B, 6'h00, 2'b01}) begin errors++; $display("FAIL nest_blocked_low: got %h expected %h", obs, {1'b0, 8'h0B, 6'h00, 2'b01}); end
        reti = 1'b1; step(); reti = 1'b0; step();
        checks++; if (obs !== {1'b1, 8'h13, 6'h00, 2'b00}) begin errors++; $display("FAIL nest_release: got %h expected %h", obs, {1'b1, 8'h13, 6'h00, 2'b00}); end
        drive(8'h87, 8'h02, 6'h00, 1'b0, 1'b0, 1'b1); step();
        checks++; if (obs !== {1'b0, 8'h13, 6'h04, 2'b01}) begin errors++; $display("FAIL nest_release_ack: got %h expected %h", obs, {1'b0, 8'h13, 6'h04, 2'b01}); end
        irq.int_ack = 1'b0; step();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    task automatic test_serial();
        drive(8'h90, 8'h00, 6'h10, 1'b1, 1'b0, 1'b0); step();
        checks++; if (obs !== {1'b1, 8'h23, 6'h00, 2'b00}) begin errors++; $display("FAIL serial_req: got %h expected %h", obs, {1'b1, 8'h23, 6'h00, 2'b00}); end
        drive(8'h90, 8'h00, 6'h10, 1'b0, 1'b0, 1'b1); step();
        checks++; if (obs !== {1'b0, 8'h23, 6'h00, 2'b01}) begin errors++; $display("FAIL serial_no_clr: got %h expected %h", obs, {1'b0, 8'h23, 6'h00, 2'b01}); end
        irq.int_ack = 1'b0; step();
        drive(8'h90, 8'h00, 6'h10, 1'b1, 1'b1, 1'b0); step();
        checks++; if (obs !== {1'b0, 8'h23, 6'h00, 2'b00}) begin errors++; $display("FAIL serial_reti_no_poll: got %h expected %h", obs, {1'b0, 8'h23, 6'h00, 2'b00}); end
        reti = 1'b0; step();
        checks++; if (obs !== {1'b1, 8'h23, 6'h00, 2'b00}) begin errors++; $display("FAIL serial_repoll: got %h expected %h", obs, {1'b1, 8'h23, 6'h00, 2'b00}); end
        drive(8'h90, 8'h00, 6'h00, 1'b0, 1'b0, 1'b1); step();
        irq.int_ack = 1'b0; step();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    task automatic test_ea_off_and_reset();
        drive(8'h3F, 8'h00, 6'h3F, 1'b1, 1'b0, 1'b0); step(); step();
        checks++; if (obs !== {1'b0, 8'h23, 6'h00, 2'b00}) begin errors++; $display("FAIL ea_off: got %h expected %h", obs, {1'b0, 8'h23, 6'h00, 2'b00}); end
        drive(8'h81, 8'h00, 6'h01, 1'b1, 1'b0, 1'b0); step();
        checks++; if (obs !== {1'b1, 8'h03, 6'h00, 2'b00}) begin errors++; $display("FAIL pre_reset_req: got %h expected %h", obs, {1'b1, 8'h03, 6'h00, 2'b00}); end
        reset = 1'b1; inst_boundary = 1'b0; step(); reset = 1'b0;
        checks++; if (obs !== 17'h0) begin errors++; $display("FAIL reset_in_req: got %h expected %h", obs, 17'h0); end
        irq.int_ack = 1'b1; step(); irq.int_ack = 1'b0;
        checks++; if (obs !== 17'h0) begin errors++; $display("FAIL ack_outside_req: got %h expected %h", obs, 17'h0); end
    endtask

    task automatic test_t2();
        drive(8'hA0, 8'h00, 6'h20, 1'b1, 1'b0, 1'b0); step();
        checks++; if (obs !== (T2 ? {1'b1, 8'h2B, 6'h00, 2'b00} : 17'h0)) begin errors++; $display("FAIL t2_req: got %h expected %h", obs, (T2 ? {1'b1, 8'h2B, 6'h00, 2'b00} : 17'h0)); end
        drive(8'hA0, 8'h00, 6'h20, 1'b0, 1'b0, T2); step();
        checks++; if (obs !== (T2 ? {1'b0, 8'h2B, 6'h00, 2'b01} : 17'h0)) begin errors++; $display("FAIL t2_ack: got %h expected %h", obs, (T2 ? {1'b0, 8'h2B, 6'h00, 2'b01} : 17'h0)); end
        drive(8'hA0, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0); step();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            IE_data       = 8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h80 : 8'h00);
            IP_data       = 8'($urandom);
            src_flags     = 6'($urandom);
            inst_boundary = 1'($urandom);
            reti          = ($urandom_range(0, 5) == 0);
            irq.int_ack   = 1'($urandom);
            step();
            checks++; if (irq.int_req !== m_req) begin errors++; $display("FAIL rand_req cyc %0d: got %b expected %b", n, irq.int_req, m_req); end
            checks++; if (irq.int_vect !== m_vect) begin errors++; $display("FAIL rand_vect cyc %0d: got %h expected %h", n, irq.int_vect, m_vect); end
            checks++; if (int_clr !== m_clr) begin errors++; $display("FAIL rand_clr cyc %0d: got %b expected %b", n, int_clr, m_clr); end
            checks++; if (in_svc !== m_svc) begin errors++; $display("FAIL rand_svc cyc %0d: got %b expected %b", n, in_svc, m_svc); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_serial();
        test_ea_off_and_reset();
        test_t2();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt controller for the 8051 core: samples the source flags from TCON/SCON (and T2CON when configured), qualifies them with the IE and IP SFR contents, and selects the highest-priority eligible source at an instruction boundary. Sits between the SFR block and the CPU control FSM. Hands the CPU a vector over a req/ack handshake, pulses hardware-clear strobes for auto-cleared flags, and tracks the two in-service priority levels until RETI.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- IE_data  in  8  IE SFR: bit7 EA, bit5 ET2, bit4 ES, bit3 ET1, bit2 EX1, bit1 ET0, bit0 EX0
- IP_data  in  8  IP SFR, same bit positions; 1 = high priority
- src_flags  in  6  bit0 IE0, bit1 TF0, bit2 IE1, bit3 TF1, bit4 RI|TI, bit5 TF2
- inst_boundary  in  1  CPU is at the last cycle of an instruction; poll allowed
- reti  in  1  one-cycle strobe, CPU executing RETI
- int_ack  in  1  CPU accepted the vector (LCALL started)
- int_req  out  1  interrupt request to CPU
- int_vect  out  8  low byte of vector address; high byte is 0x00
- int_clr  out  6  one-cycle hardware-clear strobes, same bit order as src_flags
- in_svc  out  2  bit1 high level in service, bit0 low level in service

## Operation
- Source n is eligible when src_flags[n], IE_data[n] and IE_data[7] are all 1. IE bit 6 and IP bits 6–7 are ignored.
- A high-priority eligible source is acceptable if in_svc[1]=0. A low-priority eligible source is acceptable if in_svc is 00.
- Winner: any acceptable high source beats any low source. Within the same level, the lower index wins: IE0 > TF0 > IE1 > TF1 > serial > TF2.
- Vectors: 0x03, 0x0B, 0x13, 0x1B, 0x23, 0x2B.
- FSM states:
  - IDLE: if inst_boundary=1, reti=0 and a winner exists, latch the winner's index, vector and level, then go to REQ. No poll happens in the cycle that reti is high.
  - REQ: int_req=1 and int_vect is held stable. The request is committed: changes to IE, IP or flags do not withdraw it. On int_ack=1, go to ACK.
  - ACK: int_clr pulses for the latched index, only for IE0, TF0, IE1 and TF1. Serial and TF2 are never cleared by hardware. The latched level's in_svc bit is set. Return to IDLE.
- RETI clears in_svc[1] if set, otherwise in_svc[0]. RETI with in_svc=00 has no effect.
- If reti and the ACK-state set occur in the same cycle, the clear is applied first, then the set.
- Reset, including mid-REQ or mid-ACK: state goes to IDLE, and int_req=0, int_vect=0x00, int_clr=0, in_svc=00. Pending flags are not latched, so they re-arbitrate after reset.

## Timing
- Poll at cycle N (IDLE, inst_boundary=1): int_req=1 and int_vect valid from N+1.
- int_ack sampled at cycle M: int_req=0 at M+1, int_clr pulse and in_svc update at M+1, IDLE at M+2. The earliest next poll is at M+2.
- int_ack is ignored outside REQ.
- All outputs are registered. int_clr is high for exactly one cycle.

## Configuration
- T2_INT_EN defined: source 5 (TF2, vector 0x2B) participates, gated by ET2 = IE[5] and prioritised by IP[5].
- T2_INT_EN undefined: src_flags[5], IE[5] and IP[5] are ignored, source 5 can never win, and int_clr[5] is tied to 0.

## Test plan
- Reset, then IE=0x81, IP=0x00, src_flags=000001, boundary pulse → int_req=1 and int_vect=0x03 next cycle. ack → int_clr=000001 for one cycle, in_svc=01.
- IE=0x9F, IP=0x08, flags IE0 and TF1 simultaneously, boundary → vector 0x1B at high level. After ack, in_svc=10.
- Low IE0 in service (in_svc=01), high TF0 raised (IP=0x02), boundary → nest to 0x0B. A further low IE1 request is blocked until both RETIs, after which it is taken with vector 0x13.
- Serial source (IE=0x90) accepted → vector 0x23, int_clr stays 000000. reti → in_svc back to 00. reti with boundary in the same cycle → no poll that cycle.
- EA=0 with all flags set → int_req stays 0. Reset asserted while in REQ → int_req=0 and in_svc=00 the next cycle.
- With T2_INT_EN: IE=0xA0, TF2 set → vector 0x2B, no clear strobe. Without T2_INT_EN: the same stimulus leaves int_req=0.
